// File: rtl/ifmap_sender.sv
// ifmap_sender: streams one ifmap row at a time from the global buffer to a PE row as 4-byte packets.
// Optional IFMAP_SENDER_STALL_CNT_EN adds a saturating count of cycles stalled by `full`.
package ifmap_sender_pkg;
   typedef struct packed {
      logic            valid;
      logic [4:0]      packet_idx;
      logic [3:0][7:0] data;
   } pe_in_packet_t;
endpackage

module ifmap_sender
   import ifmap_sender_pkg::*;
#(
   parameter int unsigned ROW_LEN = 227,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned MIN_GAP = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [7:0]        row_count,
   input  logic [4:0]        pkt_idx,
   input  logic              next_row,
   input  logic              full,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [31:0]       rd_data,
   output pe_in_packet_t     ifmap_packet,
   output logic              busy,
   output logic              row_done,
`ifdef IFMAP_SENDER_STALL_CNT_EN
   output logic [15:0]       stall_cnt,
`endif
   output logic              done
);

   localparam int unsigned NPKT       = (ROW_LEN + 3) / 4;
   localparam int unsigned CNT_W      = (NPKT > 1) ? $clog2(NPKT) : 1;
   localparam int unsigned LAST_BYTES = ROW_LEN - 4 * (NPKT - 1);
   localparam int unsigned GAP_LAST   = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;

   typedef enum logic [2:0] {IDLE, FETCH, HOLD, SEND, GAP, ROW_WAIT} state_t;

   state_t            state;
   logic [CNT_W-1:0]  pkt_cnt;
   logic [7:0]        row_cnt;
   logic [7:0]        row_total;
   logic [ADDR_W-1:0] row_base;
   logic [4:0]        idx_q;
   logic [31:0]       hold_q;
   logic [1:0]        gap_cnt;
   logic              last_pkt;
   logic [ADDR_W-1:0] cur_addr;

   assign last_pkt = (pkt_cnt == CNT_W'(NPKT - 1));
   assign cur_addr = row_base + ADDR_W'(pkt_cnt);

   // Bytes past the end of the row are sent as zero in the final packet.
   function automatic logic [31:0] tail_mask(input logic [31:0] d);
      logic [31:0] m;
      m = d;
      for (int k = 0; k < 4; k++) begin
         if (k >= int'(LAST_BYTES)) m[8*k +: 8] = 8'h00;
      end
      return m;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pkt_cnt   <= '0;
         row_cnt   <= '0;
         row_total <= '0;
         row_base  <= '0;
         idx_q     <= '0;
         hold_q    <= '0;
         gap_cnt   <= '0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         busy      <= 1'b0;
         row_done  <= 1'b0;
         done      <= 1'b0;
      end else begin
         rd_en    <= 1'b0;
         row_done <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  row_base  <= base_addr;
                  row_total <= row_count;
                  idx_q     <= pkt_idx;
                  pkt_cnt   <= '0;
                  row_cnt   <= '0;
                  if (row_count == 8'd0) begin
                     done <= 1'b1;
                  end else begin
                     state   <= FETCH;
                     busy    <= 1'b1;
                     rd_en   <= 1'b1;
                     rd_addr <= base_addr;
                  end
               end
            end
            FETCH: state <= HOLD;
            HOLD: begin
               hold_q <= last_pkt ? tail_mask(rd_data) : rd_data;
               state  <= SEND;
            end
            SEND: begin
               if (!full) begin
                  if (last_pkt) begin
                     row_done <= 1'b1;
                     row_cnt  <= row_cnt + 8'd1;
                     row_base <= row_base + ADDR_W'(NPKT);
                     state    <= ROW_WAIT;
                  end else begin
                     pkt_cnt <= pkt_cnt + CNT_W'(1);
                     if (MIN_GAP == 0) begin
                        state   <= FETCH;
                        rd_en   <= 1'b1;
                        rd_addr <= cur_addr + ADDR_W'(1);
                     end else begin
                        state   <= GAP;
                        gap_cnt <= '0;
                     end
                  end
               end
            end
            GAP: begin
               if (gap_cnt == 2'(GAP_LAST)) begin
                  state   <= FETCH;
                  rd_en   <= 1'b1;
                  rd_addr <= cur_addr;
               end else begin
                  gap_cnt <= gap_cnt + 2'd1;
               end
            end
            ROW_WAIT: begin
               // First cycle here is the row_done cycle; finish once all rows are out.
               if (row_done && (row_cnt == row_total)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (next_row) begin
                  pkt_cnt <= '0;
                  state   <= FETCH;
                  rd_en   <= 1'b1;
                  rd_addr <= row_base;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IFMAP_SENDER_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if ((state == IDLE) && start) begin
         stall_cnt <= '0;
      end else if ((state == SEND) && full && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

   // valid follows `full` within the SEND cycle so a stalled packet is never issued.
   always_comb begin
      ifmap_packet            = '0;
      ifmap_packet.valid      = (state == SEND) && !full;
      ifmap_packet.packet_idx = idx_q;
      ifmap_packet.data       = hold_q;
   end

endmodule
